// File: rtl/crossbar_pkg.sv
// Shared helpers for the crossbar family: select-field width sizing.
package crossbar_pkg;

    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/crossbar_out_reg.sv
// One-entry pass-through pipe register for a single crossbar output.
// Payload reads as zero whenever the entry is empty.
module crossbar_out_reg #(
    parameter int BIT_WIDTH = 32,
    parameter int ENTRIES   = 2
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              load_i,
    input  logic [ENTRIES-1:0][BIT_WIDTH-1:0] msg_i,
    input  logic                              rdy_i,
    output logic                              can_load_o,
    output logic                              val_o,
    output logic [ENTRIES-1:0][BIT_WIDTH-1:0] msg_o
);

    logic                              val_q;
    logic [ENTRIES-1:0][BIT_WIDTH-1:0] msg_q;

    assign can_load_o = !val_q || rdy_i;
    assign val_o      = val_q;
    assign msg_o      = val_q ? msg_q : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            val_q <= 1'b0;
            msg_q <= '0;
        end else if (load_i) begin
            val_q <= 1'b1;
            msg_q <= msg_i;
        end else if (rdy_i) begin
            val_q <= 1'b0;
        end
    end

endmodule

// File: rtl/crossbar_2d_mcast.sv
// Non-blocking multicast crossbar: per-output route table, per-input done
// masks, and registered outputs. Inputs retire once all destinations load.
module crossbar_2d_mcast
    import crossbar_pkg::*;
#(
    parameter int BIT_WIDTH = 32,
    parameter int N_INPUTS  = 4,
    parameter int N_OUTPUTS = 4,
    parameter int ENTRIES   = 2,
    localparam int IN_SEL_W  = sel_w(N_INPUTS),
    localparam int OUT_SEL_W = sel_w(N_OUTPUTS)
) (
    input  logic                                              clk_i,
    input  logic                                              rst_ni,
    input  logic [N_INPUTS-1:0][ENTRIES-1:0][BIT_WIDTH-1:0]   recv_msg_i,
    input  logic [N_INPUTS-1:0]                               recv_val_i,
    output logic [N_INPUTS-1:0]                               recv_rdy_o,
    output logic [N_OUTPUTS-1:0][ENTRIES-1:0][BIT_WIDTH-1:0]  send_msg_o,
    output logic [N_OUTPUTS-1:0]                              send_val_o,
    input  logic [N_OUTPUTS-1:0]                              send_rdy_i,
    input  logic [OUT_SEL_W-1:0]                              cfg_out_i,
    input  logic [IN_SEL_W-1:0]                               cfg_in_i,
    input  logic                                              cfg_en_i,
    input  logic                                              cfg_val_i,
    output logic                                              cfg_rdy_o
);

    logic [N_OUTPUTS-1:0]                en_q, en_d;
    logic [N_OUTPUTS-1:0][IN_SEL_W-1:0]  src_q, src_d;
    logic [N_INPUTS-1:0][N_OUTPUTS-1:0]  done_q, done_d;
    logic [N_INPUTS-1:0][N_OUTPUTS-1:0]  dest;
    logic [N_OUTPUTS-1:0]                can_load, load, out_val;
    logic                                cfg_fire, cfg_hit;

    // Routes may only change when nothing is in flight anywhere.
    assign cfg_rdy_o  = ~|out_val && ~|done_q;
    assign cfg_fire   = cfg_val_i && cfg_rdy_o;
    assign cfg_hit    = cfg_fire && (int'(cfg_out_i) < N_OUTPUTS) && (int'(cfg_in_i) < N_INPUTS);
    assign send_val_o = out_val;

    always_comb begin
        load       = '0;
        dest       = '0;
        recv_rdy_o = '0;
        done_d     = done_q;
        for (int o = 0; o < N_OUTPUTS; o++) begin
            load[o] = en_q[o] && recv_val_i[src_q[o]] && !done_q[src_q[o]][o]
                      && can_load[o] && !cfg_fire;
        end
        for (int i = 0; i < N_INPUTS; i++) begin
            for (int o = 0; o < N_OUTPUTS; o++) begin
                dest[i][o] = en_q[o] && (src_q[o] == IN_SEL_W'(i));
            end
            // Retire only when every destination is done or loading now.
            recv_rdy_o[i] = |dest[i] && ((dest[i] & ~(done_q[i] | load)) == '0) && !cfg_fire;
            if (recv_val_i[i] && recv_rdy_o[i]) begin
                done_d[i] = '0;
            end else begin
                done_d[i] = done_q[i] | (load & dest[i]);
            end
        end
    end

    always_comb begin
        en_d  = en_q;
        src_d = src_q;
        for (int o = 0; o < N_OUTPUTS; o++) begin
            if (cfg_hit && (int'(cfg_out_i) == o)) begin
                en_d[o]  = cfg_en_i;
                src_d[o] = cfg_in_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            en_q   <= '0;
            src_q  <= '0;
            done_q <= '0;
        end else begin
            en_q   <= en_d;
            src_q  <= src_d;
            done_q <= done_d;
        end
    end

    for (genvar o = 0; o < N_OUTPUTS; o++) begin : g_out
        crossbar_out_reg #(
            .BIT_WIDTH (BIT_WIDTH),
            .ENTRIES   (ENTRIES)
        ) u_out_reg (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .load_i     (load[o]),
            .msg_i      (recv_msg_i[src_q[o]]),
            .rdy_i      (send_rdy_i[o]),
            .can_load_o (can_load[o]),
            .val_o      (out_val[o]),
            .msg_o      (send_msg_o[o])
        );
    end

endmodule

// File: tb/tb_crossbar_2d_mcast.sv
// Bench for crossbar_2d_mcast: directed scenarios plus random traffic,
// all checked each cycle against a message-level reference model.
module tb_crossbar_2d_mcast;

    localparam int BW = 32;
    localparam int NI = 4;
    localparam int NO = 4;
    localparam int NE = 2;

    logic                          clk = 1'b0;
    logic                          rst_n;
    logic [NI-1:0][NE-1:0][BW-1:0] recv_msg;
    logic [NI-1:0]                 recv_val;
    logic [NI-1:0]                 recv_rdy;
    logic [NO-1:0][NE-1:0][BW-1:0] send_msg;
    logic [NO-1:0]                 send_val;
    logic [NO-1:0]                 send_rdy;
    logic [1:0]                    cfg_out;
    logic [1:0]                    cfg_in;
    logic                          cfg_en;
    logic                          cfg_val;
    logic                          cfg_rdy;

    always #5 clk = ~clk;

    crossbar_2d_mcast #(
        .BIT_WIDTH (BW),
        .N_INPUTS  (NI),
        .N_OUTPUTS (NO),
        .ENTRIES   (NE)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .recv_msg_i (recv_msg),
        .recv_val_i (recv_val),
        .recv_rdy_o (recv_rdy),
        .send_msg_o (send_msg),
        .send_val_o (send_val),
        .send_rdy_i (send_rdy),
        .cfg_out_i  (cfg_out),
        .cfg_in_i   (cfg_in),
        .cfg_en_i   (cfg_en),
        .cfg_val_i  (cfg_val),
        .cfg_rdy_o  (cfg_rdy)
    );

    int n_chk = 0;
    int n_err = 0;

    // Reference model: routes, what each output holds, and which
    // destinations have already taken each input's current message.
    bit                   m_en   [NO];
    int                   m_src  [NO];
    bit                   m_full [NO];
    logic [NE-1:0][BW-1:0] m_msg [NO];
    bit                   m_served [NI][NO];

    logic [NI-1:0] last_rdy;
    logic          last_crdy;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int o = 0; o < NO; o++) begin
            m_en[o] = 0; m_src[o] = 0; m_full[o] = 0; m_msg[o] = '0;
        end
        for (int i = 0; i < NI; i++)
            for (int o = 0; o < NO; o++) m_served[i][o] = 0;
    endtask

    // Compare one cycle against the model, then advance the model past the edge.
    task automatic step();
        bit                            busy, fire;
        bit                            takes [NO];
        logic [NI-1:0]                 rdy_e;
        logic [NO-1:0]                 val_e;
        logic [NO-1:0][NE-1:0][BW-1:0] msg_e;
        @(negedge clk);
        busy = 0;
        for (int o = 0; o < NO; o++) if (m_full[o]) busy = 1;
        for (int i = 0; i < NI; i++)
            for (int o = 0; o < NO; o++) if (m_served[i][o]) busy = 1;
        fire = cfg_val && !busy;
        for (int o = 0; o < NO; o++)
            takes[o] = !fire && m_en[o] && recv_val[m_src[o]] && !m_served[m_src[o]][o]
                       && (!m_full[o] || send_rdy[o]);
        for (int i = 0; i < NI; i++) begin
            int  n_dest = 0;
            bit  all_ok = 1;
            for (int o = 0; o < NO; o++)
                if (m_en[o] && m_src[o] == i) begin
                    n_dest++;
                    if (!(m_served[i][o] || takes[o])) all_ok = 0;
                end
            rdy_e[i] = (n_dest > 0) && all_ok;
        end
        for (int o = 0; o < NO; o++) begin
            val_e[o] = m_full[o];
            msg_e[o] = m_full[o] ? m_msg[o] : '0;
        end
        chk("send_val", send_val, val_e);
        chk("send_msg", send_msg, msg_e);
        chk("recv_rdy", recv_rdy, rdy_e);
        chk("cfg_rdy", cfg_rdy, !busy);
        last_rdy  = recv_rdy;
        last_crdy = cfg_rdy;
        for (int i = 0; i < NI; i++) begin
            if (recv_val[i] && rdy_e[i]) begin
                for (int o = 0; o < NO; o++) m_served[i][o] = 0;
            end else begin
                for (int o = 0; o < NO; o++) if (takes[o] && m_src[o] == i) m_served[i][o] = 1;
            end
        end
        for (int o = 0; o < NO; o++) begin
            if (takes[o]) begin
                m_full[o] = 1;
                m_msg[o]  = recv_msg[m_src[o]];
            end else if (send_rdy[o]) begin
                m_full[o] = 0;
            end
        end
        if (fire && int'(cfg_out) < NO && int'(cfg_in) < NI) begin
            m_en[cfg_out]  = cfg_en;
            m_src[cfg_out] = int'(cfg_in);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int o, input int i, input bit en);
        cfg_out = 2'(o); cfg_in = 2'(i); cfg_en = en; cfg_val = 1'b1;
        recv_val = '0;
        step();
        cfg_val = 1'b0;
    endtask

    task automatic idle(input int n);
        recv_val = '0; send_rdy = '1;
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic rand_msgs();
        for (int i = 0; i < NI; i++)
            for (int e = 0; e < NE; e++) recv_msg[i][e] = $urandom;
    endtask

    initial begin
        logic [NE-1:0][BW-1:0] exp_m;
        rst_n = 1'b0; recv_msg = '0; recv_val = '0; send_rdy = '0;
        cfg_out = '0; cfg_in = '0; cfg_en = 1'b0; cfg_val = 1'b0;
        model_reset();
        #3;
        chk("rst_send_val", send_val, '0);
        chk("rst_send_msg", send_msg, '0);
        chk("rst_recv_rdy", recv_rdy, '0);
        chk("rst_cfg_rdy", cfg_rdy, 1'b1);
        #10 rst_n = 1'b1;

        // Unicast out0 <- in2
        cfg(0, 2, 1'b1);
        recv_msg[2][0] = 32'hA; recv_msg[2][1] = 32'hB;
        recv_val = 4'b0100; send_rdy = '1;
        step();
        chk("uni_rdy", last_rdy[2], 1'b1);
        recv_val = '0;
        exp_m[0] = 32'hA; exp_m[1] = 32'hB;
        chk("uni_val", send_val, 4'b0001);
        chk("uni_msg", send_msg[0], exp_m);
        idle(2);

        // Two disjoint unicast streams
        cfg(0, 0, 1'b1);
        cfg(1, 1, 1'b1);
        send_rdy = '1;
        for (int k = 0; k < 6; k++) begin
            rand_msgs();
            recv_val = 4'b0011;
            step();
            chk("conc_rdy", last_rdy[1:0], 2'b11);
        end
        idle(2);

        // Multicast in1 -> out0, out1, out3 with out3 stalled
        cfg(0, 1, 1'b1);
        cfg(3, 1, 1'b1);
        send_rdy = 4'b0111;
        rand_msgs(); recv_val = 4'b0010;
        step();
        chk("mc_first_rdy", last_rdy[1], 1'b1);
        rand_msgs();
        step();
        chk("mc_skew_rdy", last_rdy[1], 1'b0);
        step();
        step();
        chk("mc_nodup", send_val[1:0], 2'b00);
        send_rdy = '1;
        step();
        chk("mc_last_rdy", last_rdy[1], 1'b1);
        chk("mc_out3", send_val[3], 1'b1);
        idle(2);

        // Unrouted input never retires
        recv_val = 4'b1000;
        for (int k = 0; k < 20; k++) step();
        chk("unr_rdy", last_rdy[3], 1'b0);
        chk("unr_val", send_val, '0);
        idle(1);

        // Config gating on a held output
        cfg(2, 2, 1'b1);
        rand_msgs(); recv_val = 4'b0100; send_rdy = 4'b1011;
        step();
        recv_val = '0;
        step();
        chk("gate_busy", last_crdy, 1'b0);
        send_rdy = '1;
        step();
        step();
        chk("gate_idle", last_crdy, 1'b1);
        rand_msgs();
        cfg_out = 2'd2; cfg_in = 2'd0; cfg_en = 1'b1; cfg_val = 1'b1;
        recv_val = 4'b0001;
        step();
        chk("gate_noload", send_val, '0);
        cfg_val = 1'b0;
        step();
        chk("gate_load", send_val[2], 1'b1);
        idle(2);

        // Asynchronous reset in the middle of a multicast
        send_rdy = 4'b0111;
        rand_msgs(); recv_val = 4'b0010;
        step();
        rand_msgs();
        step();
        rst_n = 1'b0;
        #2;
        chk("arst_val", send_val, '0);
        chk("arst_rdy", recv_rdy, '0);
        chk("arst_cfg", cfg_rdy, 1'b1);
        model_reset();
        #1 rst_n = 1'b1;
        step();
        chk("arst_route", last_rdy[1], 1'b0);

        // Random traffic with random reconfiguration
        for (int k = 0; k < 400; k++) begin
            if (k % 50 == 49) begin
                idle(3);
            end else begin
                rand_msgs();
                recv_val = 4'($urandom);
                send_rdy = 4'($urandom | $urandom);
                cfg_val  = ($urandom_range(0, 5) == 0);
                cfg_out  = 2'($urandom);
                cfg_in   = 2'($urandom);
                cfg_en   = ($urandom_range(0, 3) != 0);
                step();
                cfg_val = 1'b0;
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/crossbar_2d_mcast.md
# crossbar_2d_mcast

Non-blocking, multicast-capable successor to the blocking 2-D crossbar. Each output has its own programmable route (an enable bit plus a source input index), so disjoint input/output pairs move data concurrently. An input routed to several outputs is acknowledged only once every destination has taken the message. Every output carries a one-entry pipeline register, so valid and data are registered at the output. The block sits between the 2-D-array producers and consumers in the datapath, wherever channel reconfiguration happens at packet boundaries.

## Interface
- BIT_WIDTH, 32, width of one entry
- N_INPUTS, 4, number of input ports (≥1)
- N_OUTPUTS, 4, number of output ports (≥1)
- ENTRIES, 2, entries per port
- localparam IN_SEL_W = max(1, $clog2(N_INPUTS)); OUT_SEL_W = max(1, $clog2(N_OUTPUTS))

- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- recv_msg  in  [BIT_WIDTH] x [N_INPUTS][ENTRIES]  input payloads
- recv_val  in  1 x [N_INPUTS]  input valid
- recv_rdy  out  1 x [N_INPUTS]  input accepted (message retired)
- send_msg  out  [BIT_WIDTH] x [N_OUTPUTS][ENTRIES]  output payloads
- send_val  out  1 x [N_OUTPUTS]  output valid
- send_rdy  in  1 x [N_OUTPUTS]  output consumer ready
- cfg_out  in  OUT_SEL_W  output whose route is written
- cfg_in  in  IN_SEL_W  new source input for cfg_out
- cfg_en  in  1  new enable for cfg_out
- cfg_val  in  1  config write request
- cfg_rdy  out  1  config write can be accepted

## Operation
- Route table: en[o], src[o] for each output. Reset: en=0, src=0. D_i = {o : en[o] && src[o]==i}.
- Output register o holds out_val[o] and out_msg[o]. It can load when out_val[o]==0 or send_rdy[o]==1 (pass-through pipe, one entry). send_val = out_val. send_msg[o] is all-zero whenever send_val[o]==0.
- Done mask done[i] (N_OUTPUTS bits, one per input) records outputs already served by the current message of input i.
- Load of output o in a cycle requires all of: en[o]; recv_val[src[o]]; !done[src[o]][o]; output o can load; and no config fire this cycle. The load copies all ENTRIES of recv_msg[src[o]].
- recv_rdy[i]=1 iff D_i is non-empty and every o in D_i is done or loading this cycle. An input with empty D_i stalls (recv_rdy=0) and is never dropped.
- recv_val&&recv_rdy clears done[i]. Otherwise done[i] |= the outputs loaded this cycle.
- Out-of-range cfg_out (≥N_OUTPUTS) or cfg_in (≥N_INPUTS) is accepted and ignored.
- cfg_rdy = (no out_val set) && (no done bit set). It depends on state only.
- On a config fire, no output loads and all recv_rdy=0 that cycle. The table updates at the edge.
- Each output has exactly one source, so no arbitration is needed.

## Timing
- Latency: a message loaded at edge t shows send_val=1 in the cycle after edge t. It holds until send_rdy.
- Throughput: 1 message/cycle per output with send_rdy held high.
- Stall: with send_rdy=0, out_msg and out_val are held stable.
- Multicast to k outputs: recv_rdy pulses in the cycle the last outstanding destination loads. Destinations may load in different cycles.
- Config takes effect for loads in the cycle after the fire.
- Reset asserted mid-transfer: all send_val=0, recv_rdy=0, cfg_rdy=1 immediately, with no clock needed. In-flight data is lost and routes return to disabled.
- Reset values: send_val=0, send_msg=0, recv_rdy=0, cfg_rdy=1.

## Structure
- Package crossbar_pkg holds the sel_w(n) function (max(1,$clog2(n))), shared with the other crossbars.
- Sub-module crossbar_out_reg holds the one-entry pipe register per output (ENTRIES x BIT_WIDTH payload plus val, with the zero-when-invalid output). It is instantiated N_OUTPUTS times by generate.
- The top level contains the route table, the done masks and the combinational load/rdy logic.

## Test plan
- Unicast: route out0←in2. Drive in2 {0xA,0xB} with send_rdy0=1 -> recv_rdy2=1 same cycle; send_val0=1 with send_msg0={0xA,0xB} next cycle; all other send_val=0.
- Concurrency: routes out0←in0 and out1←in1, both valid every cycle -> both outputs stream 1/cycle with no mutual stall.
- Multicast skew: out0, out1 and out3 all ←in1. Hold send_rdy3=0 with out3 already full -> out0/out1 load once; recv_rdy1 stays 0 with no duplicate on out0/out1. Raise send_rdy3 -> out3 loads and recv_rdy1=1 that cycle.
- Unrouted input: in3 valid with no route -> recv_rdy3=0 for 20 cycles, all send_val=0.
- Config gating: while out2 holds data with send_rdy2=0 -> cfg_rdy=0. After drain -> cfg_rdy=1. Fire cfg (out2←in0, en=1) with in0 valid -> no load that cycle; load occurs the next cycle.
- Async reset: pull reset low between clock edges mid-multicast -> send_val all 0 immediately. After release, in1 valid -> recv_rdy=0 because routes are disabled.
